ifetch_pair: RTL and testbench
==============================

Name: ifetch_pair

Overview:
- Dual-issue instruction fetch unit for the superscalar pipeline. It is the initiator side of the instruction-memory read interface.
- Drives a word address and receives two consecutive instruction words per cycle: rd = word at a, rd2 = word at a+4.
- Packs the two words, with their PC, into a fetch packet and buffers packets in a small FIFO.
- Presents packets to decode over a valid/ready handshake and handles branch/jump redirects with a flush.

Parameters:
- DEPTH, 4, fetch FIFO depth in packets; power of two, at least 2.
- RESET_PC, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-low reset (reset==0 resets on the clock edge).
- imem_a  out  32  instruction memory word address, equal to the PC register.
- imem_rd  in  32  combinational read data, word at imem_a.
- imem_rd2  in  32  combinational read data, word at imem_a+4.
- redirect_valid  in  1  redirect request from execute (taken branch/jump).
- redirect_pc  in  32  redirect target.
- out_valid  out  1  FIFO head holds a packet.
- out_ready  in  1  decode accepts the head packet this cycle.
- out_pc  out  32  PC of slot 0 of the head packet.
- out_instr0  out  32  slot-0 instruction.
- out_instr1  out  32  slot-1 instruction.
- out_valid1  out  1  slot 1 is issuable.
- occupancy  out  $clog2(DEPTH)+1  packets currently buffered.

Behaviour:
- Reset (reset==0 at an edge):
  - pc <= RESET_PC; FIFO emptied.
  - out_valid=0, occupancy=0.
  - out_pc, out_instr0, out_instr1 and out_valid1 read 0 while empty.
  - Reset wins over all other inputs, including mid-stream and during a redirect.
- imem_a = pc, combinational from the register. The memory is zero-latency, so read data is sampled in the same cycle.
- deq = out_valid & out_ready.
- enq_ok = !redirect_valid & (occupancy<DEPTH | deq). A full FIFO with a simultaneous dequeue still enqueues.
- Fetch cycle with enq_ok:
  - Push packet {pc, imem_rd, imem_rd2, v1=1}.
  - pc <= pc+8, modulo 2^32 (0xFFFFFFF8 -> 0x00000000).
- Cycle without enq_ok and without redirect: pc holds and imem_a is stable. No packet is lost or duplicated.
- Redirect cycle (redirect_valid=1):
  - All FIFO entries are discarded at the edge, so occupancy is 0 next cycle.
  - No enqueue happens in that cycle.
  - pc <= {redirect_pc[31:2],2'b00}; low bits are silently forced to 0.
  - A head accepted by decode in the same cycle (deq=1) counts as consumed; decode sees it before the flush.
- Redirect has priority over fetch; reset has priority over redirect.
- First packet after a redirect appears with out_valid=1 one cycle after the redirect edge, i.e. two-cycle redirect penalty.
- FIFO ordering:
  - Strict FIFO; head outputs come directly from storage, not combinationally from imem.
  - Read/write pointers wrap modulo DEPTH.
  - Occupancy: +1 on enq only, -1 on deq only, unchanged when both happen.
- Instruction word 0 is a NOP and is not special-cased.

Optional Feature:
- Macro IFETCH_PREDECODE_EN.
- Defined:
  - Slot 0 is predecoded on imem_rd[31:26] ∈ {6'h02 j, 6'h03 jal, 6'h04 beq, 6'h05 bne}.
  - On a match the packet is pushed with v1=0, and pc advances by 4 instead of 8, so the word in slot 1 is refetched as slot 0 of the next packet.
  - Result: a control instruction always ends a packet.
- Undefined: v1 is always 1 and pc always advances by 8. No predecode logic is present.

Decomposition:
- Package ifetch_pkg:
  - fetch-packet struct {pc[31:0], instr0[31:0], instr1[31:0], v1}.
  - PC_STEP_PAIR=8, PC_STEP_SINGLE=4.
  - Opcode constants OP_J, OP_JAL, OP_BEQ, OP_BNE.
- Sub-module ifetch_fifo:
  - Parameterised by DEPTH.
  - Ports: push, pop, flush, packet in/out, occupancy, full, empty.
- ifetch_pair keeps the PC register, enq/redirect control and the optional predecode.

Test Plan:
- Reset held low 3 cycles with out_ready=1 → imem_a=0, out_valid=0, occupancy=0. After release, packets have pc 0x0,0x8,0x10 with instr0/instr1 = RAM[0]/RAM[1], RAM[2]/RAM[3], RAM[4]/RAM[5].
- out_ready=0 for 10 cycles, DEPTH=4:
  - occupancy reaches 4 and imem_a freezes at 0x20.
  - Then out_ready=1: packets 0x0..0x18 drain in order, 0x20 follows with no gap, no drop and no duplicate.
- Redirect to 0x26 while FIFO holds 3 packets, with out_ready=1 on the same cycle:
  - Head consumed; occupancy=0 next cycle.
  - Next packet pc=0x24 with RAM[9]/RAM[10]; out_valid low for exactly one cycle between.
- FIFO full plus simultaneous deq → enqueue occurs; occupancy stays 4 and the pc advances by 8.
- reset low mid-stream with a simultaneous redirect → pc=RESET_PC and FIFO empty; redirect ignored.
- IFETCH_PREDECODE_EN, RAM[2]=beq at pc 0x8:
  - Packet pc=0x8 has out_valid1=0.
  - Next packet pc=0xC with RAM[3]/RAM[4].
  - Without the macro: packet 0x8 has out_valid1=1 and the next packet is pc=0x10.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types and constants for the dual-issue fetch unit:
//            fetch-packet layout, PC step sizes and the control-flow opcodes
//            recognised by the optional slot-0 predecoder.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    typedef struct packed {
        logic [31:0] pc;      // PC of slot 0
        logic [31:0] instr0;  // word at pc
        logic [31:0] instr1;  // word at pc+4
        logic        v1;      // slot 1 may be issued
    } fetch_pkt_t;

    localparam logic [31:0] PC_STEP_PAIR   = 32'd8;
    localparam logic [31:0] PC_STEP_SINGLE = 32'd4;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // True when the primary opcode is a jump or branch.
    function automatic logic is_ctrl(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Purpose  : Fetch-packet FIFO, DEPTH entries (power of two, >= 2).
//            Head data is read straight from storage; reads 0 when empty.
// Ports    : clk, reset (sync, active-low), push/din, pop/dout, flush,
//            occupancy, full, empty.
//            A push while full is accepted only with a simultaneous pop.
//            flush empties the FIFO at the edge and overrides push.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_pkt_t               din,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_pkt_t               dout,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    fetch_pkt_t     r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign occupancy = r_count;
    assign dout      = empty ? '0 : r_mem[r_rptr];

    assign w_do_pop  = pop & ~empty;
    // When full, the slot freed by a same-cycle pop is exactly the write slot.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_pair.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pair
// Purpose  : Dual-issue instruction fetch. Reads two consecutive words per
//            cycle from a zero-latency instruction memory, packs them with
//            their PC into a fetch packet and queues packets for decode.
//            Redirects flush the queue and reload the PC.
// Ports    : clk, reset (sync, active-low)
//            imem_a / imem_rd / imem_rd2 : memory read port (word at a, a+4)
//            redirect_valid / redirect_pc : taken branch/jump from execute
//            out_valid / out_ready / out_pc / out_instr0 / out_instr1 /
//            out_valid1 : packet handshake to decode
//            occupancy : packets currently buffered
// Config   : `define IFETCH_PREDECODE_EN to end a packet after a slot-0
//            jump/branch (slot 1 invalid, PC advances by 4).
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_pair
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_a,
    input  logic [31:0]              imem_rd,
    input  logic [31:0]              imem_rd2,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr0,
    output logic [31:0]              out_instr1,
    output logic                     out_valid1,
    output logic [$clog2(DEPTH):0]   occupancy
);

    logic [31:0] r_pc;
    logic        w_deq;
    logic        w_enq_ok;
    logic        w_full;
    logic        w_empty;
    logic        w_v1;
    logic [31:0] w_step;
    fetch_pkt_t  w_pkt_in;
    fetch_pkt_t  w_pkt_out;
    logic [1:0]  w_unused_redirect_lsb;

    // Redirect targets are word aligned; the byte-offset bits are dropped.
    assign w_unused_redirect_lsb = redirect_pc[1:0];

    assign imem_a    = r_pc;
    assign out_valid = ~w_empty;
    assign w_deq     = out_valid & out_ready;
    assign w_enq_ok  = ~redirect_valid & (~w_full | w_deq);

`ifdef IFETCH_PREDECODE_EN
    logic w_is_ctrl;
    // A control instruction in slot 0 closes the packet so that slot 1 is
    // refetched as the next packet's slot 0.
    assign w_is_ctrl = is_ctrl(imem_rd[31:26]);
    assign w_v1      = ~w_is_ctrl;
    assign w_step    = w_is_ctrl ? PC_STEP_SINGLE : PC_STEP_PAIR;
`else
    assign w_v1      = 1'b1;
    assign w_step    = PC_STEP_PAIR;
`endif

    assign w_pkt_in = '{pc: r_pc, instr0: imem_rd, instr1: imem_rd2, v1: w_v1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_enq_ok) begin
            r_pc <= r_pc + w_step;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_enq_ok),
        .din       (w_pkt_in),
        .pop       (w_deq),
        .flush     (redirect_valid),
        .dout      (w_pkt_out),
        .occupancy (occupancy),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_pc     = w_pkt_out.pc;
    assign out_instr0 = w_pkt_out.instr0;
    assign out_instr1 = w_pkt_out.instr1;
    assign out_valid1 = w_pkt_out.v1;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_pair.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_pair
// Purpose  : Self-checking bench for ifetch_pair. A behavioural model (packet
//            queue plus PC) predicts every output each cycle; directed steps
//            are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_pair;

    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   imem_a;
    logic [31:0]   imem_rd;
    logic [31:0]   imem_rd2;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr0;
    logic [31:0]   out_instr1;
    logic          out_valid1;
    logic [OW-1:0] occupancy;

    logic [31:0] ram [64];
    logic [31:0] a_plus4;

    assign a_plus4  = imem_a + 32'd4;
    assign imem_rd  = ram[imem_a[7:2]];
    assign imem_rd2 = ram[a_plus4[7:2]];

    always #5 clk = ~clk;

    ifetch_pair #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .imem_rd2       (imem_rd2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr0     (out_instr0),
        .out_instr1     (out_instr1),
        .out_valid1     (out_valid1),
        .occupancy      (occupancy)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        v1;
    } pkt_t;

    pkt_t        q[$];
    logic [31:0] m_pc;
    bit          m_known = 0;
    int          checks  = 0;
    int          errors  = 0;

    function automatic logic [31:0] mem(input logic [31:0] addr);
        return ram[addr[7:2]];
    endfunction

    function automatic bit ends_packet(input logic [31:0] w);
`ifdef IFETCH_PREDECODE_EN
        return (w[31:26] >= 6'h02) && (w[31:26] <= 6'h05);
`else
        return w[31:26] == 6'h3F && 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model mid-cycle,
    // advance the model by the cycle's rules, then let the edge happen.
    task automatic step(input logic rst_n, input logic rv, input logic [31:0] rpc,
                        input logic rdy);
        bit   deq;
        bit   can_enq;
        bit   ctl;
        pkt_t p;
        reset          = rst_n;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(negedge clk);
        if (m_known) begin
            chk("imem_a", imem_a, m_pc);
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_instr0", out_instr0, q[0].i0);
                chk("out_instr1", out_instr1, q[0].i1);
                chk("out_valid1", 32'(out_valid1), 32'(q[0].v1));
            end else begin
                chk("empty_pc", out_pc, 32'h0);
                chk("empty_instr0", out_instr0, 32'h0);
                chk("empty_instr1", out_instr1, 32'h0);
                chk("empty_valid1", 32'(out_valid1), 32'h0);
            end
        end
        if (!rst_n) begin
            q.delete();
            m_pc    = 32'h0;
            m_known = 1;
        end else if (m_known) begin
            if (rv) begin
                q.delete();
                m_pc = rpc & ~32'h3;
            end else begin
                deq     = (q.size() != 0) && rdy;
                can_enq = (q.size() < DEPTH) || deq;
                if (deq) void'(q.pop_front());
                if (can_enq) begin
                    ctl  = ends_packet(mem(m_pc));
                    p.pc = m_pc;
                    p.i0 = mem(m_pc);
                    p.i1 = mem(m_pc + 32'd4);
                    p.v1 = !ctl;
                    q.push_back(p);
                    m_pc = m_pc + (ctl ? 32'd4 : 32'd8);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Random words whose opcode is never a jump/branch.
    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] >= 6'h02 && w[31:26] <= 6'h05) w[31:26] = 6'h08;
        return w;
    endfunction

    logic [31:0] exp_third_pc;
    logic [31:0] exp_third_i0;
    logic        exp_v1_at8;

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        for (int i = 0; i < 64; i++) ram[i] = plain_word();

        // Reset held low for three cycles.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_imem_a", imem_a, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_occ", 32'(occupancy), 32'h0);

        // Streaming with decode always ready.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_i0", out_instr0, ram[0]);
        chk("first_i1", out_instr1, ram[1]);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("second_pc", out_pc, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("third_pc", out_pc, 32'h10);
        chk("third_i0", out_instr0, ram[4]);
        chk("third_i1", out_instr1, ram[5]);

        // Back-pressure: fill and freeze.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_occ", 32'(occupancy), 32'd4);
        chk("stall_a", imem_a, 32'h20);
        // Full with a dequeue still enqueues.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("fulldeq_occ", 32'(occupancy), 32'd4);
        chk("fulldeq_a", imem_a, 32'h28);
        chk("fulldeq_head", out_pc, 32'h8);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect to a misaligned target with three packets queued.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre_redir_occ", 32'(occupancy), 32'd3);
        step(1'b1, 1'b1, 32'h26, 1'b1);
        chk("redir_occ", 32'(occupancy), 32'h0);
        chk("redir_valid", 32'(out_valid), 32'h0);
        chk("redir_a", imem_a, 32'h24);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("post_redir_valid", 32'(out_valid), 32'h1);
        chk("post_redir_pc", out_pc, 32'h24);
        chk("post_redir_i0", out_instr0, ram[9]);
        chk("post_redir_i1", out_instr1, ram[10]);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_a", imem_a, 32'h0);
        chk("wrap_pc", out_pc, 32'hFFFF_FFF8);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset wins over a simultaneous redirect.
        step(1'b0, 1'b1, 32'h40, 1'b1);
        chk("rst_redir_a", imem_a, 32'h0);
        chk("rst_redir_occ", 32'(occupancy), 32'h0);

        // Branch in slot 0 at pc 0x8.
        ram[2] = {6'h04, 26'h000_0003};
`ifdef IFETCH_PREDECODE_EN
        exp_v1_at8   = 1'b0;
        exp_third_pc = 32'hC;
        exp_third_i0 = ram[3];
`else
        exp_v1_at8   = 1'b1;
        exp_third_pc = 32'h10;
        exp_third_i0 = ram[4];
`endif
        step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("br_pc", out_pc, 32'h8);
        chk("br_v1", 32'(out_valid1), 32'(exp_v1_at8));
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("br_next_pc", out_pc, exp_third_pc);
        chk("br_next_i0", out_instr0, exp_third_i0);

        // Randomized phase, control opcodes allowed.
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            if ($urandom_range(0, 5) == 0) ram[i][31:26] = 6'($urandom_range(2, 5));
        end
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 11) == 0),
                 32'($urandom_range(0, 255)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
